// File: rtl/adder_col_ctrl.sv
// adder_col_ctrl: sequences beats into an adder column, then captures and hands off the group sum; ADDER_COL_CTRL_ERR_EN enables the beat-overrun guard
module adder_col_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 4,
    parameter int MAX_BEATS  = 16,
    parameter int ADD_LAT    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_ROWS-1:0]            in_mask,
    input  logic                           in_last,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] col_data_in,
    output logic [NUM_ROWS-1:0]            adder_en,
    output logic [NUM_ROWS-1:0]            visible,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] out_data,
    output logic                           err
);
    localparam int TW = ADD_LAT < 1 ? 1 : $clog2(ADD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t        state, state_nx;
    logic          xfer, overrun, close, drain_done;
    logic [TW-1:0] dcnt;

    assign in_ready   = state == IDLE || state == ACCUM;
    assign out_valid  = state == OUT;
    assign xfer       = in_valid && in_ready;
    assign close      = xfer && (in_last || overrun);
    assign drain_done = state == DRAIN && dcnt == TW'(ADD_LAT);

`ifdef ADDER_COL_CTRL_ERR_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [CW-1:0] cnt;

    assign overrun = xfer && !in_last && cnt == CW'(MAX_BEATS - 1);

    // beat counter restarts whenever the controller heads back to IDLE
    always_ff @(posedge clk) begin
        if (rst || (state == OUT && out_ready))
            cnt <= '0;
        else if (xfer)
            cnt <= cnt + 1'b1;
    end

    // overrun flag stays set until reset
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (overrun)
            err <= 1'b1;
    end
`else
    assign overrun = 1'b0;
    assign err     = 1'b0;
`endif

    // next-state selection
    always_comb begin
        state_nx = state;
        if (state == IDLE || state == ACCUM)
            state_nx = close ? DRAIN : xfer ? ACCUM : state;
        else if (state == DRAIN)
            state_nx = drain_done ? OUT : DRAIN;
        else
            state_nx = out_ready ? IDLE : OUT;
    end

    // state, column drive, drain timer and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dcnt        <= '0;
            col_data_in <= '0;
            adder_en    <= '0;
            visible     <= '0;
            out_data    <= '0;
        end else begin
            state       <= state_nx;
            col_data_in <= xfer ? in_data : '0;
            visible     <= xfer ? in_mask : '0;
            adder_en    <= {NUM_ROWS{xfer && state == ACCUM}};
            dcnt        <= state == DRAIN && !drain_done ? dcnt + 1'b1 : '0;
            if (drain_done)
                out_data <= result;
        end
    end
endmodule

// File: tb/tb_adder_col_ctrl.sv
// tb_adder_col_ctrl: table, directed and randomized checks of adder_col_ctrl against a row-sum model
module tb_adder_col_ctrl;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int AL = 1;
    localparam int W  = NR * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [NR-1:0] in_mask;
    logic          in_last;
    logic [W-1:0]  col_data_in;
    logic [NR-1:0] adder_en;
    logic [NR-1:0] visible;
    logic [W-1:0]  result;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] col [NR];
    logic [DW-1:0] ref_rows [NR];

    typedef struct {
        int              n;
        logic [2:0][W-1:0]  d;
        logic [2:0][NR-1:0] m;
        int              bub;
        int              stall;
        logic [W-1:0]    exp;
    } vec_t;

    vec_t tv [6];

    always #5 clk = ~clk;

    adder_col_ctrl #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .MAX_BEATS(MB), .ADD_LAT(AL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mask(in_mask), .in_last(in_last), .col_data_in(col_data_in), .adder_en(adder_en),
        .visible(visible), .result(result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .err(err)
    );

    // adder column stand-in: one-cycle registered load/accumulate per row
    always @(posedge clk)
        for (int r = 0; r < NR; r++)
            if (rst) col[r] <= '0;
            else if (visible[r]) col[r] <= (adder_en[r] ? col[r] : '0) + col_data_in[r*DW +: DW];

    always_comb
        for (int r = 0; r < NR; r++) result[r*DW +: DW] = col[r];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void ref_beat(logic [W-1:0] d, logic [NR-1:0] m, bit first);
        for (int r = 0; r < NR; r++)
            if (m[r]) ref_rows[r] = DW'((first ? 0 : int'(ref_rows[r])) + int'(d[r*DW +: DW]));
    endfunction

    function automatic logic [W-1:0] pack_ref();
        logic [W-1:0] v;
        for (int r = 0; r < NR; r++) v[r*DW +: DW] = ref_rows[r];
        return v;
    endfunction

    task automatic send_beat(logic [W-1:0] d, logic [NR-1:0] m, bit last, bit first);
        int t = 0;
        logic [NR-1:0] en_exp;
        en_exp = first ? '0 : '1;
        in_valid = 1'b1; in_data = d; in_mask = m; in_last = last;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("beat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_mask = '0;
        chk("adder_en", adder_en, en_exp);
        chk("visible", visible, m);
        chk("col_data_in", col_data_in, d);
        ref_beat(d, m, first);
    endtask

    task automatic get_out(int stall, logic [W-1:0] exp);
        int t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, exp);
        in_valid = 1'b1; in_last = 1'b1; in_data = '1; in_mask = '1;
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, exp);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_mask = '0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1, {32'h0, 32'h0, 32'h1E19E67D}, {4'h0, 4'h0, 4'hF}, 0, 5, 32'h1E19E67D};
        tv[1] = '{3, {32'h0A0A0A0A, 32'h0A0A0A0A, 32'h0A0A0A0A}, {4'hF, 4'hF, 4'hF}, 0, 0, 32'h1E1E1E1E};
        tv[2] = '{2, {32'h0, 32'h05050505, 32'h05050505}, {4'h0, 4'b0101, 4'hF}, 1, 1, 32'h050A050A};
        tv[3] = '{2, {32'h0, 32'h90909090, 32'h80808080}, {4'h0, 4'hF, 4'hF}, 2, 0, 32'h10101010};
        tv[4] = '{3, {32'h01010101, 32'h10101010, 32'h01020304}, {4'hF, 4'h0, 4'hF}, 0, 2, 32'h02030405};
        tv[5] = '{1, {32'h0, 32'h0, 32'h11111111}, {4'h0, 4'h0, 4'b0011}, 0, 0, 32'h02031111};
        for (int r = 0; r < NR; r++) ref_rows[r] = '0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_visible", visible, 0);
        chk("rst_adder_en", adder_en, 0);
        chk("rst_col_data", col_data_in, 0);
        chk("rst_err", err, 0);

        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < tv[v].n; b++) begin
                send_beat(tv[v].d[b], tv[v].m[b], b == tv[v].n - 1, b == 0);
                if (b != tv[v].n - 1)
                    repeat (tv[v].bub) begin
                        @(posedge clk); #1;
                        chk("bubble_in_ready", in_ready, 1);
                        chk("bubble_visible", visible, 0);
                    end
            end
            get_out(tv[v].stall, tv[v].exp);
        end

        send_beat(32'h01010101, 4'hF, 1'b0, 1'b1);
        send_beat(32'h02020202, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < NR; r++) ref_rows[r] = '0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_visible", visible, 0);
        chk("abort_adder_en", adder_en, 0);
        chk("abort_col_data", col_data_in, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_err", err, 0);
        repeat (4) @(posedge clk);
        #1 chk("abort_out_valid", out_valid, 0);
        send_beat(32'h03030303, 4'hF, 1'b0, 1'b1);
        send_beat(32'h04040404, 4'hF, 1'b1, 1'b0);
        get_out(0, 32'h07070707);

        for (int g = 0; g < 40; g++) begin
            int len = $urandom_range(1, MB);
            for (int b = 0; b < len; b++) begin
                send_beat(W'($urandom), NR'($urandom), b == len - 1, b == 0);
                if (b != len - 1)
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                        chk("rnd_bubble_ready", in_ready, 1);
                    end
            end
            get_out($urandom_range(0, 3), pack_ref());
        end

`ifdef ADDER_COL_CTRL_ERR_EN
        for (int b = 0; b < 4; b++) begin
            send_beat({4{8'(b + 1)}}, 4'hF, 1'b0, b == 0);
            if (b == 2) chk("err_before_max", err, 0);
        end
        chk("err_at_max", err, 1);
        chk("err_in_ready", in_ready, 0);
        get_out(1, 32'h0A0A0A0A);
        chk("err_sticky", err, 1);
`else
        for (int b = 0; b < 6; b++) send_beat({4{8'(b + 1)}}, 4'hF, 1'b0, b == 0);
        chk("noerr_err", err, 0);
        chk("noerr_in_ready", in_ready, 1);
        send_beat({4{8'd7}}, 4'hF, 1'b1, 1'b0);
        get_out(0, 32'h1C1C1C1C);
        chk("noerr_err_end", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
